shift_serializer: RTL and testbench
===================================

// Module: shift_serializer
// PURPOSE
//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
//   handshake and drives it one bit per CLK edge onto shift_out, the serial stream
//   the Registrador shift register consumes on its Shift_in port.
//   Frame markers (shift_valid, frame_last) let the receiver or a bench align to words.
// PARAMETERS
//   WIDTH      4   data bits per frame (>=2)
//   MSB_FIRST  0   0: bit 0 transmitted first; 1: bit WIDTH-1 transmitted first
// PORTS
//   CLK          in   1      clock, all state updates on rising edge
//   Reset        in   1      asynchronous, active-low reset (0 = reset)
//   load_data    in   WIDTH  parallel word to transmit
//   load_valid   in   1      load_data valid; hold valid and data stable until accepted
//   load_ready   out  1      block can accept a word this cycle
//   shift_out    out  1      serial data bit, registered
//   shift_valid  out  1      shift_out carries a frame bit this cycle, registered
//   frame_last   out  1      shift_out carries the final bit of the frame, registered
// BEHAVIOUR
//   - Reset low: state=IDLE, shift_out=0, shift_valid=0, frame_last=0, counter=0, data reg=0.
//     Takes effect immediately, mid-frame included; the partial frame is dropped and not resumed.
//   - States: IDLE, SHIFT (and PARITY when enabled). Counter is $clog2(WIDTH) bits.
//   - load_ready = (state==IDLE) | (state==SHIFT & last data bit & no parity) | (state==PARITY).
//     Combinational from state/counter only, never from load_valid.
//   - Accept = load_valid & load_ready at a rising edge: capture word, counter=0,
//     state=SHIFT; first bit appears on shift_out with shift_valid=1 the same edge.
//     Latency: 1 cycle from accept edge to first bit; frame occupies WIDTH cycles.
//   - Each SHIFT edge: present next bit (LSB or MSB order per MSB_FIRST), counter+1.
//   - frame_last=1 exactly while the final bit of the frame is on shift_out.
//   - After last bit: if accept occurs that edge -> new frame starts with no gap cycle
//     (back-to-back streaming); else -> IDLE, shift_valid=0, shift_out=0.
//   - load_valid while load_ready=0: ignored, no capture, no state change.
//   - load_data changes while load_valid=1 and load_ready=0: protocol violation, unspecified.
//   - Counter never wraps; it reloads to 0 on every accept.
// CONFIGURATION
//   SERIALIZER_PARITY_EN defined: after WIDTH data bits, state PARITY sends one even-parity
//     bit (XOR of captured word); frame = WIDTH+1 cycles; frame_last moves to parity cycle;
//     load_ready high in PARITY instead of on the last data bit.
//   Undefined: no PARITY state, frame = WIDTH cycles, no parity logic synthesized.
// STRUCTURE
//   Package shift_serializer_pkg: state encoding constants (IDLE/SHIFT/PARITY),
//     default WIDTH, counter-width helper.
//   One sub-module: serializer_bit_counter (clear on accept, increment in SHIFT,
//     terminal-count flag at WIDTH-1); datapath and FSM stay in shift_serializer.
// TESTING
//   1. WIDTH=4, MSB_FIRST=0, accept 4'b1011 -> shift_out 1,1,0,1 on 4 edges, shift_valid=1
//      for 4 cycles, frame_last only on 4th, then IDLE with outputs 0.
//   2. Back-to-back: 4'b1011 then 4'b0100 held valid -> 8 consecutive valid bits
//      1,1,0,1,0,0,1,0, no gap cycle, frame_last on cycles 4 and 8.
//   3. Reset asserted low after 2nd bit of 4'b1111 -> outputs 0 immediately (before next edge),
//      load_ready=1 after release; next word 4'b0001 transmitted intact.
//   4. load_valid pulsed with 4'b0110 mid-frame while load_ready=0 -> ignored; current frame
//      completes unchanged, no extra frame.
//   5. MSB_FIRST=1, accept 4'b1000 -> shift_out 1,0,0,0.
//   6. SERIALIZER_PARITY_EN, accept 4'b1011 -> 1,1,0,1 then parity 1; frame_last on 5th bit;
//      4'b0011 -> parity 0.

Source files
------------

// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the shift_serializer PISO transmitter.
// State encoding, default frame width and bit-counter width helper.
package shift_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Counter must be at least one bit wide even for the smallest legal frame.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// Load handshake and serial frame signals of the shift_serializer.
// slave = serializer side, master = word producer / frame observer.
interface shift_serializer_if import shift_serializer_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_out;
  logic             shift_valid;
  logic             frame_last;

  modport master (
    output load_data, load_valid,
    input  load_ready, shift_out, shift_valid, frame_last
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, shift_out, shift_valid, frame_last
  );
endinterface

// File: rtl/serializer_bit_counter.sv
// Index of the data bit currently on shift_out; cleared on accept,
// advanced while shifting, saturates at WIDTH-1 with a terminal flag.
module serializer_bit_counter import shift_serializer_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW   = cnt_width(WIDTH)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  assign terminal = (count == LAST_CNT);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !terminal) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and frame markers.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module shift_serializer import shift_serializer_pkg::*; #(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              Reset,
  shift_serializer_if.slave bus
);

  localparam int unsigned   CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_IDX = MSB_FIRST ? LAST_CNT : '0;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [CW-1:0]    count;
  logic [CW-1:0]    next_count;
  logic [CW-1:0]    next_idx;
  logic             terminal;
  logic             ready;
  logic             accept;
  logic             shift_out_q;
  logic             shift_valid_q;
  logic             frame_last_q;

`ifdef SERIALIZER_PARITY_EN
  assign ready = (state == ST_IDLE) || (state == ST_PARITY);
`else
  assign ready = (state == ST_IDLE) || ((state == ST_SHIFT) && terminal);
`endif

  assign accept     = bus.load_valid && ready;
  assign next_count = count + CW'(1);
  assign next_idx   = MSB_FIRST ? (LAST_CNT - next_count) : next_count;

  serializer_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .CLK      (CLK),
    .Reset    (Reset),
    .clear    (accept),
    .advance  (state == ST_SHIFT),
    .count    (count),
    .terminal (terminal)
  );

  // Accept has priority: on the last bit it restarts the frame with no gap.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      data          <= '0;
      shift_out_q   <= 1'b0;
      shift_valid_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else if (accept) begin
      state         <= ST_SHIFT;
      data          <= bus.load_data;
      shift_out_q   <= bus.load_data[FIRST_IDX];
      shift_valid_q <= 1'b1;
      frame_last_q  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (!terminal) begin
            shift_out_q   <= data[next_idx];
            shift_valid_q <= 1'b1;
            frame_last_q  <= !PARITY_EN && (next_count == LAST_CNT);
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state         <= ST_PARITY;
            shift_out_q   <= ^data;
            shift_valid_q <= 1'b1;
            frame_last_q  <= 1'b1;
`else
            state         <= ST_IDLE;
            shift_out_q   <= 1'b0;
            shift_valid_q <= 1'b0;
            frame_last_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state         <= ST_IDLE;
          shift_out_q   <= 1'b0;
          shift_valid_q <= 1'b0;
          frame_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = ready;
  assign bus.shift_out   = shift_out_q;
  assign bus.shift_valid = shift_valid_q;
  assign bus.frame_last  = frame_last_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: LSB-first and MSB-first instances share stimulus
// and are checked against a queue model of the expected serial frames.
module tb_shift_serializer;
  import shift_serializer_pkg::*;

  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic b;
    logic last;
  } ent_t;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic [W-1:0] data = '0;
  logic         valid = 1'b0;

  int checks = 0;
  int errors = 0;

  ent_t q_lsb[$];
  ent_t q_msb[$];

  shift_serializer_if #(.WIDTH(W)) bus_lsb ();
  shift_serializer_if #(.WIDTH(W)) bus_msb ();

  assign bus_lsb.load_data  = data;
  assign bus_lsb.load_valid = valid;
  assign bus_msb.load_data  = data;
  assign bus_msb.load_valid = valid;

  shift_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .CLK(CLK), .Reset(Reset), .bus(bus_lsb)
  );
  shift_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .CLK(CLK), .Reset(Reset), .bus(bus_msb)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_lsb.push_back('{b: w[i],         last: (i == W - 1) && !PAR});
      q_msb.push_back('{b: w[W - 1 - i], last: (i == W - 1) && !PAR});
    end
    if (PAR) begin
      q_lsb.push_back('{b: ^w, last: 1'b1});
      q_msb.push_back('{b: ^w, last: 1'b1});
    end
  endtask

  // A new word is taken only when nothing beyond the current bit remains.
  function automatic logic model_ready();
    return q_lsb.size() <= 1;
  endfunction

  task automatic check_outputs();
    ent_t e;
    if (q_lsb.size() == 0) begin
      chk("lsb_valid_idle", bus_lsb.shift_valid, 1'b0);
      chk("lsb_out_idle",   bus_lsb.shift_out,   1'b0);
      chk("lsb_last_idle",  bus_lsb.frame_last,  1'b0);
      chk("msb_valid_idle", bus_msb.shift_valid, 1'b0);
      chk("msb_out_idle",   bus_msb.shift_out,   1'b0);
      chk("msb_last_idle",  bus_msb.frame_last,  1'b0);
    end else begin
      e = q_lsb[0];
      chk("lsb_valid", bus_lsb.shift_valid, 1'b1);
      chk("lsb_out",   bus_lsb.shift_out,   e.b);
      chk("lsb_last",  bus_lsb.frame_last,  e.last);
      e = q_msb[0];
      chk("msb_valid", bus_msb.shift_valid, 1'b1);
      chk("msb_out",   bus_msb.shift_out,   e.b);
      chk("msb_last",  bus_msb.frame_last,  e.last);
    end
  endtask

  task automatic step(output bit acc);
    logic r;
    r = model_ready();
    chk("lsb_ready", bus_lsb.load_ready, r);
    chk("msb_ready", bus_msb.load_ready, r);
    acc = valid && r;
    @(posedge CLK);
    #1;
    if (q_lsb.size() > 0) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (acc) push_frame(data);
    check_outputs();
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc;
    acc = 1'b0;
    data  = w;
    valid = 1'b1;
    for (int k = 0; k < 3 * W + 4 && !acc; k++) step(acc);
    checks++;
    assert (acc === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout: observed accepted=%b expected 1 for word %b", acc, w);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    valid = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    q_lsb.delete();
    q_msb.delete();
    check_outputs();
    #2;
    Reset = 1'b1;
    chk("lsb_ready_after_reset", bus_lsb.load_ready, 1'b1);
    chk("msb_ready_after_reset", bus_msb.load_ready, 1'b1);
  endtask

  initial begin
    bit acc;
    #3;
    check_outputs();
    chk("lsb_ready_reset", bus_lsb.load_ready, 1'b1);
    chk("msb_ready_reset", bus_msb.load_ready, 1'b1);
    Reset = 1'b1;

    // Single frame, then idle.
    send(4'b1011);
    idle(W + 3);

    // Back-to-back streaming.
    send(4'b1011);
    send(4'b0100);
    idle(W + 3);

    // Reset mid-frame after the second bit, then an intact word.
    send(4'b1111);
    idle(1);
    pulse_reset();
    send(4'b0001);
    idle(W + 3);

    // Load attempt while busy is ignored.
    send(4'b1011);
    data  = 4'b0110;
    valid = 1'b1;
    step(acc);
    idle(W + 3);

    // Single-one words exercise bit ordering; parity words of odd/even weight.
    send(4'b1000);
    idle(W + 2);
    send(4'b0011);
    idle(W + 2);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(W'($urandom));
    end
    idle(W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
